// File: rtl/sram_1w1r_pkg.sv
// sram_1w1r_pkg -- shared constants and helpers for the banked 1W1R SRAM.
//   DEF_*        : default parameter values used by the top and the bank.
//   nbanks()     : number of banks for a given address split.
//   bsel_w()     : width of the bank-select field (at least 1 bit).
//   CNT_SAT_FILL : bit value that fills a saturated collision counter.
package sram_1w1r_pkg;

    localparam int DEF_ADDR_W      = 6;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_BANK_ADDR_W = 4;
    localparam int DEF_CNT_W       = 16;

    // A saturated counter is all ones: {CNT_W{CNT_SAT_FILL}} == 2^CNT_W-1.
    localparam logic CNT_SAT_FILL = 1'b1;

    function automatic int nbanks(input int addr_w, input int bank_addr_w);
        return 1 << (addr_w - bank_addr_w);
    endfunction

    // A single-bank build still carries a 1-bit (constant zero) select.
    function automatic int bsel_w(input int addr_w, input int bank_addr_w);
        return (addr_w > bank_addr_w) ? (addr_w - bank_addr_w) : 1;
    endfunction

endpackage

// File: rtl/sram_1w1r_bank.sv
// sram_1w1r_bank -- one 2^BANK_ADDR_W x DATA_W bank, read-first, bit-masked
// write, registered read data (1-cycle latency).
//   CLK      : clock, rising edge
//   wen_i    : write enable (already qualified by bank select and reset)
//   waddr_i  : in-bank write address
//   wdata_i  : write data
//   wmask_i  : per-bit write mask, 1 = write
//   ren_i    : read enable (already qualified by bank select and reset)
//   raddr_i  : in-bank read address
//   rdata_o  : registered read data; holds its value when ren_i is low
module sram_1w1r_bank
    import sram_1w1r_pkg::*;
#(
    parameter int BANK_ADDR_W = DEF_BANK_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W
) (
    input  logic                   CLK,
    input  logic                   wen_i,
    input  logic [BANK_ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0]      wdata_i,
    input  logic [DATA_W-1:0]      wmask_i,
    input  logic                   ren_i,
    input  logic [BANK_ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0]      rdata_o
);

    // Storage is deliberately not reset: contents survive RSTN.
    logic [DATA_W-1:0] mem_q [2**BANK_ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Both accesses use non-blocking updates, so a same-address read in the
    // write cycle observes the old word (read-first).
    always_ff @(posedge CLK) begin
        if (wen_i) begin
            mem_q[waddr_i] <= (mem_q[waddr_i] & ~wmask_i) | (wdata_i & wmask_i);
        end
        if (ren_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_1w1r_banked.sv
// sram_1w1r_banked -- banked one-write/one-read SRAM with collision counter.
//   CLK, RSTN         : clock (rising edge), async active-low reset
//   CE0, WE0, A0, D0  : write port enable, strobe, address, data
//   WEM0              : per-bit write mask, 1 = write
//   CE1, A1           : read port enable and address
//   Q1, Q1_VALID      : read data (zero when not valid), 1 cycle after CE1
//   COLL_CNT          : saturating count of same-address write/read cycles
// Build option: define SRAM_1W1R_BANKED_FWD_EN for write-first collision
// reads (write data forwarded into Q1); default is read-first (old word).
module sram_1w1r_banked
    import sram_1w1r_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int BANK_ADDR_W = DEF_BANK_ADDR_W,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              CE0,
    input  logic [ADDR_W-1:0] A0,
    input  logic [DATA_W-1:0] D0,
    input  logic              WE0,
    input  logic [DATA_W-1:0] WEM0,
    input  logic              CE1,
    input  logic [ADDR_W-1:0] A1,
    output logic [DATA_W-1:0] Q1,
    output logic              Q1_VALID,
    output logic [CNT_W-1:0]  COLL_CNT
);

    localparam int NBANKS = nbanks(ADDR_W, BANK_ADDR_W);
    localparam int BSEL_W = bsel_w(ADDR_W, BANK_ADDR_W);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{CNT_SAT_FILL}};

    logic [BSEL_W-1:0] wbank, rbank;
    logic              wr_en, rd_en, coll;

    // Ports are ignored while reset is held.
    assign wr_en = CE0 & WE0 & RSTN;
    assign rd_en = CE1 & RSTN;
    assign coll  = wr_en & rd_en & (A0 == A1);

    if (ADDR_W > BANK_ADDR_W) begin : g_bsel
        assign wbank = A0[ADDR_W-1:BANK_ADDR_W];
        assign rbank = A1[ADDR_W-1:BANK_ADDR_W];
    end else begin : g_bsel_one
        assign wbank = '0;
        assign rbank = '0;
    end

    logic [NBANKS-1:0][DATA_W-1:0] rdata;

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        sram_1w1r_bank #(
            .BANK_ADDR_W(BANK_ADDR_W),
            .DATA_W     (DATA_W)
        ) u_bank (
            .CLK    (CLK),
            .wen_i  (wr_en && (wbank == BSEL_W'(b))),
            .waddr_i(A0[BANK_ADDR_W-1:0]),
            .wdata_i(D0),
            .wmask_i(WEM0),
            .ren_i  (rd_en && (rbank == BSEL_W'(b))),
            .raddr_i(A1[BANK_ADDR_W-1:0]),
            .rdata_o(rdata[b])
        );
    end

    // Read bank travels with the valid bit so the output mux always picks
    // the bank that was read on the previous edge.
    logic              vld_q;
    logic [BSEL_W-1:0] rbank_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    assign cnt_d = (coll && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            vld_q   <= 1'b0;
            rbank_q <= '0;
            cnt_q   <= '0;
        end else begin
            vld_q   <= rd_en;
            rbank_q <= rd_en ? rbank : rbank_q;
            cnt_q   <= cnt_d;
        end
    end

    logic [DATA_W-1:0] word;

`ifdef SRAM_1W1R_BANKED_FWD_EN
    // Bank returns the old word on a collision; merge the write in here.
    logic              fwd_q;
    logic [DATA_W-1:0] fwd_d_q, fwd_m_q;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            fwd_q   <= 1'b0;
            fwd_d_q <= '0;
            fwd_m_q <= '0;
        end else begin
            fwd_q   <= coll;
            fwd_d_q <= coll ? D0   : fwd_d_q;
            fwd_m_q <= coll ? WEM0 : fwd_m_q;
        end
    end

    assign word = fwd_q ? ((rdata[rbank_q] & ~fwd_m_q) | (fwd_d_q & fwd_m_q))
                        : rdata[rbank_q];
`else
    assign word = rdata[rbank_q];
`endif

    assign Q1       = vld_q ? word : '0;
    assign Q1_VALID = vld_q;
    assign COLL_CNT = cnt_q;

endmodule

// File: tb/tb_sram_1w1r_banked.sv
module tb_sram_1w1r_banked;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        CE0, WE0, CE1;
    logic [5:0]  A0, A1;
    logic [15:0] D0, WEM0;
    logic [15:0] Q1, Q1s;
    logic        Q1_VALID, Q1_VALIDs;
    logic [15:0] COLL_CNT;
    logic [3:0]  COLL_CNTs;

    int n_chk = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    sram_1w1r_banked u_dut (
        .CLK(CLK), .RSTN(RSTN), .CE0(CE0), .A0(A0), .D0(D0), .WE0(WE0),
        .WEM0(WEM0), .CE1(CE1), .A1(A1), .Q1(Q1), .Q1_VALID(Q1_VALID),
        .COLL_CNT(COLL_CNT)
    );

    // Same stimulus, narrow counter for the saturation check.
    sram_1w1r_banked #(.CNT_W(4)) u_sat (
        .CLK(CLK), .RSTN(RSTN), .CE0(CE0), .A0(A0), .D0(D0), .WE0(WE0),
        .WEM0(WEM0), .CE1(CE1), .A1(A1), .Q1(Q1s), .Q1_VALID(Q1_VALIDs),
        .COLL_CNT(COLL_CNTs)
    );

`ifdef SRAM_1W1R_BANKED_FWD_EN
    localparam logic [15:0] COLL_EXP = 16'h1234;
`else
    localparam logic [15:0] COLL_EXP = 16'h0000;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle away from it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        CE0 = 0; WE0 = 0; CE1 = 0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [15:0] d, input logic [15:0] m);
        CE0 = 1; WE0 = 1; A0 = a; D0 = d; WEM0 = m;
        step();
        idle();
    endtask

    task automatic rd(input string tag, input logic [5:0] a, input logic [15:0] exp);
        CE1 = 1; A1 = a;
        step();
        idle();
        chk({tag, "_vld"}, Q1_VALID, 1);
        chk(tag, Q1, exp);
    endtask

    initial begin
        RSTN = 0; idle(); A0 = 0; A1 = 0; D0 = 0; WEM0 = 0;
        step(); step();
        chk("rst_vld", Q1_VALID, 0);
        chk("rst_q1", Q1, 0);
        chk("rst_cnt", COLL_CNT, 0);
        RSTN = 1;

        // Basic write / read, then valid drops with data forced to zero.
        wr(6'h03, 16'hA5A5, 16'hFFFF);
        rd("rd03", 6'h03, 16'hA5A5);
        step();
        chk("idle_vld", Q1_VALID, 0);
        chk("idle_q1", Q1, 0);

        // Back-to-back reads across banks 0 and 1.
        wr(6'h05, 16'h1111, 16'hFFFF);
        wr(6'h15, 16'h2222, 16'hFFFF);
        CE1 = 1; A1 = 6'h05;
        step();
        A1 = 6'h15;
        chk("b2b_0", Q1, 16'h1111);
        step();
        idle();
        chk("b2b_1", Q1, 16'h2222);
        chk("b2b_1_vld", Q1_VALID, 1);

        // Strobe or enable low leaves memory alone.
        CE0 = 1; WE0 = 0; A0 = 6'h05; D0 = 16'hFFFF; WEM0 = 16'hFFFF;
        step();
        CE0 = 0; WE0 = 1;
        step();
        idle();
        rd("nowr05", 6'h05, 16'h1111);

        // Masked write: only the low byte changes.
        wr(6'h03, 16'hBEEF, 16'h00FF);
        rd("mask03", 6'h03, 16'hA5EF);

        // Same bank, different addresses, same cycle.
        CE0 = 1; WE0 = 1; A0 = 6'h08; D0 = 16'h5A5A; WEM0 = 16'hFFFF;
        CE1 = 1; A1 = 6'h03;
        step();
        idle();
        chk("samebank_rd", Q1, 16'hA5EF);
        rd("samebank_wr", 6'h08, 16'h5A5A);
        chk("nocoll_cnt", COLL_CNT, 0);

        // Collision on 0x07.
        wr(6'h07, 16'h0000, 16'hFFFF);
        CE0 = 1; WE0 = 1; A0 = 6'h07; D0 = 16'h1234; WEM0 = 16'hFFFF;
        CE1 = 1; A1 = 6'h07;
        step();
        idle();
        chk("coll_q1", Q1, COLL_EXP);
        chk("coll_cnt", COLL_CNT, 1);
        rd("coll_after", 6'h07, 16'h1234);

        // Read, then reset for two cycles while hammering the write port.
        CE1 = 1; A1 = 6'h03;
        step();
        CE1 = 0;
        RSTN = 0;
        CE0 = 1; WE0 = 1; A0 = 6'h03; D0 = 16'h0000; WEM0 = 16'hFFFF;
        #1;
        chk("arst_vld", Q1_VALID, 0);
        chk("arst_q1", Q1, 0);
        chk("arst_cnt", COLL_CNT, 0);
        step(); step();
        idle();
        RSTN = 1;
        step();
        chk("post_rst_vld", Q1_VALID, 0);
        rd("retain03", 6'h03, 16'hA5EF);

        // 20 collisions, then one more: narrow counter pins at 0xF.
        CE0 = 1; WE0 = 1; CE1 = 1; A0 = 6'h20; A1 = 6'h20;
        D0 = 16'h0F0F; WEM0 = 16'hFFFF;
        for (int i = 0; i < 20; i++) step();
        chk("sat_cnt", COLL_CNTs, 4'hF);
        chk("wide_cnt", COLL_CNT, 20);
        step();
        idle();
        chk("sat_hold", COLL_CNTs, 4'hF);
        chk("wide_cnt21", COLL_CNT, 21);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
